// File: rtl/change_dispenser_pkg.sv
// Shared vending datapath definitions: money width, coin encodings/values, dispenser states.
package change_pkg;

    localparam int unsigned MONEY_W = 7;
    typedef logic [MONEY_W-1:0] money_t;

    // Same 2-bit encoding as the datapath add/divisor selects.
    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_2  = 2'b01,
        COIN_10 = 2'b10,
        COIN_20 = 2'b11
    } coin_t;

    localparam money_t VAL_1  = 7'd1;
    localparam money_t VAL_2  = 7'd2;
    localparam money_t VAL_10 = 7'd10;
    localparam money_t VAL_20 = 7'd20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_REL    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-facing signals of change_dispenser; err exists only with CHANGE_TIMEOUT_EN.
interface change_dispenser_if;

    logic                         start;
    logic [change_pkg::MONEY_W-1:0] amount;
    logic                         coin_ack;
    logic                         coin_req;
    logic [1:0]                   coin_type;
    logic                         busy;
    logic                         done;
    logic [change_pkg::MONEY_W-1:0] remaining;
    logic [change_pkg::MONEY_W-1:0] coins_out;
`ifdef CHANGE_TIMEOUT_EN
    logic                         err;
`endif

    modport slave (
        input  start, amount, coin_ack,
        output coin_req, coin_type, busy, done, remaining, coins_out
`ifdef CHANGE_TIMEOUT_EN
        , err
`endif
    );

    modport master (
        output start, amount, coin_ack,
        input  coin_req, coin_type, busy, done, remaining, coins_out
`ifdef CHANGE_TIMEOUT_EN
        , err
`endif
    );

endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin choice: largest denomination not exceeding the amount still owed.
module coin_selector
    import change_pkg::*;
(
    input  money_t remaining,
    output coin_t  coin_type,
    output money_t denom
);

    always_comb begin
        coin_type = COIN_1;
        denom     = VAL_1;
        if (remaining >= VAL_20) begin
            coin_type = COIN_20;
            denom     = VAL_20;
        end else if (remaining >= VAL_10) begin
            coin_type = COIN_10;
            denom     = VAL_10;
        end else if (remaining >= VAL_2) begin
            coin_type = COIN_2;
            denom     = VAL_2;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change as coins over a four-phase req/ack hopper handshake.
// Optional ack watchdog and ERR state enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input logic CLK,
    input logic RST_N,
    change_dispenser_if.slave bus
);

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_cfg_check
        $error("change_dispenser: ACK_TIMEOUT must be within 1..255");
    end

    state_t state, state_n;
    money_t remaining_q, coins_q, denom_q, sel_denom;
    coin_t  coin_q, sel_type;
    logic   req_q, busy_q, done_q;

    coin_selector u_sel (
        .remaining (remaining_q),
        .coin_type (sel_type),
        .denom     (sel_denom)
    );

`ifdef CHANGE_TIMEOUT_EN
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);
    logic [7:0] wdog_q;
    logic       err_q;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (bus.start) state_n = ST_SELECT;
            ST_SELECT: state_n = (remaining_q == '0) ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (bus.coin_ack) state_n = ST_REL;
`ifdef CHANGE_TIMEOUT_EN
                else if (wdog_q == ACK_LIMIT) state_n = ST_ERR;
`endif
            end
            ST_REL:    if (!bus.coin_ack) state_n = ST_SELECT;
            ST_DONE:   state_n = ST_IDLE;
`ifdef CHANGE_TIMEOUT_EN
            ST_ERR:    if (bus.start) state_n = ST_SELECT;
`endif
            default:   state_n = ST_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they align with the state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            coins_q     <= '0;
            denom_q     <= '0;
            coin_q      <= COIN_1;
        end else begin
            state  <= state_n;
            req_q  <= (state_n == ST_REQ);
            busy_q <= (state_n != ST_IDLE);
            done_q <= (state_n == ST_DONE);
            if ((state == ST_IDLE || state == ST_ERR) && bus.start) begin
                remaining_q <= bus.amount;
                coins_q     <= '0;
            end
            if (state == ST_SELECT && remaining_q != '0) begin
                coin_q  <= sel_type;
                denom_q <= sel_denom;
            end
            if (state == ST_REL && !bus.coin_ack) begin
                remaining_q <= remaining_q - denom_q;
                coins_q     <= coins_q + money_t'(1);
            end
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state_n == ST_ERR);
            if (state != ST_REQ) wdog_q <= '0;
            else                 wdog_q <= wdog_q + 8'd1;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.coin_req  = req_q;
    assign bus.coin_type = coin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;
    assign bus.coins_out = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser with a behavioural greedy-change reference and hopper model.
module tb_change_dispenser;

`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned ACK_TO = 8;
`else
    localparam int unsigned ACK_TO = 255;
`endif

    typedef struct {
        int ctype;
        int rem;
        int cnt;
    } coin_exp_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    change_dispenser_if bus();

    change_dispenser #(.ACK_TIMEOUT(ACK_TO)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    coin_exp_t coin_q[$];
    int        done_q[$];
    int        n_checks = 0;
    int        n_fail = 0;
    bit        hop_en = 1'b0;
    int        hop_dly = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: repeatedly hand out the biggest coin that fits.
    task automatic plan(input int amt);
        int r = amt;
        int n = 0;
        while (r > 0) begin
            int v;
            int t;
            if (r >= 20)      begin v = 20; t = 3; end
            else if (r >= 10) begin v = 10; t = 2; end
            else if (r >= 2)  begin v = 2;  t = 1; end
            else              begin v = 1;  t = 0; end
            coin_q.push_back('{ctype: t, rem: r, cnt: n});
            r -= v;
            n++;
        end
        done_q.push_back(n);
    endtask

    // Hopper: follows coin_req after hop_dly extra cycles in each phase.
    initial begin
        int cnt = 0;
        bus.coin_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (!hop_en || !RST_N) begin
                bus.coin_ack = 1'b0;
                cnt = 0;
            end else if (bus.coin_req != bus.coin_ack) begin
                if (cnt >= hop_dly) begin
                    bus.coin_ack = bus.coin_req;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a coin or reports done.
    initial begin
        bit        prev_req = 1'b0;
        bit        prev_done = 1'b0;
        int        prev_type = 0;
        coin_exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.coin_req && !prev_req) begin
                    if (coin_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL coin_extra: got request for coin_type %0d, expected no request", bus.coin_type);
                    end else begin
                        e = coin_q.pop_front();
                        check("coin_type", int'(bus.coin_type), e.ctype);
                        check("remaining_before_coin", int'(bus.remaining), e.rem);
                        check("coins_out_before_coin", int'(bus.coins_out), e.cnt);
                    end
                end else if (bus.coin_req && prev_req) begin
                    check("coin_type_stable", int'(bus.coin_type), prev_type);
                end
                if (prev_done) begin
                    check("done_one_cycle", int'(bus.done), 0);
                    check("busy_after_done", int'(bus.busy), 0);
                end
                if (bus.done && !prev_done) begin
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL done_extra: got done pulse, expected none");
                    end else begin
                        check("coins_out_at_done", int'(bus.coins_out), done_q.pop_front());
                        check("remaining_at_done", int'(bus.remaining), 0);
                    end
                end
                prev_req  = bus.coin_req;
                prev_type = int'(bus.coin_type);
                prev_done = bus.done;
            end
        end
    end

    task automatic run(input int amt, input bit mid_start, output int lat);
        bit got = 1'b0;
        lat = -1;
        plan(amt);
        @(negedge CLK);
        bus.amount = 7'(amt);
        bus.start  = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
`ifdef CHANGE_TIMEOUT_EN
        check("err_clear_after_start", int'(bus.err), 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if (bus.done) begin
                got = 1'b1;
                lat = i;
                break;
            end
            if (mid_start && i == 12) begin
                bus.amount = 7'd99;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge CLK);
        end
        bus.start = 1'b0;
        check("done_within_bound", int'(got), 1);
        check("all_coins_issued", coin_q.size(), 0);
        @(negedge CLK);
        check("done_queue_drained", done_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int amt;
        bit got;
        bus.start  = 1'b0;
        bus.amount = '0;
        repeat (2) @(negedge CLK);
        check("rst_coin_req", int'(bus.coin_req), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_remaining", int'(bus.remaining), 0);
        check("rst_coins_out", int'(bus.coins_out), 0);
        check("rst_coin_type", int'(bus.coin_type), 0);
`ifdef CHANGE_TIMEOUT_EN
        check("rst_err", int'(bus.err), 0);
`endif
        RST_N  = 1'b1;
        hop_en = 1'b1;

        hop_dly = 0;
        run(33, 1'b0, lat);
        run(0, 1'b0, lat);
        check("zero_amount_done_latency", lat, 1);
        run(127, 1'b0, lat);

        hop_dly = 5;
        run(33, 1'b1, lat);

        // Reset while a coin request is outstanding.
        hop_en = 1'b0;
        coin_q.push_back('{ctype: 3, rem: 20, cnt: 0});
        @(negedge CLK);
        bus.amount = 7'd20;
        bus.start  = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.coin_req) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("req_before_reset", int'(got), 1);
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_coin_req", int'(bus.coin_req), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_remaining", int'(bus.remaining), 0);
        check("async_rst_coins_out", int'(bus.coins_out), 0);
        check("async_rst_coin_type", int'(bus.coin_type), 0);
        coin_q.delete();
        done_q.delete();
        @(negedge CLK);
        RST_N   = 1'b1;
        hop_en  = 1'b1;
        hop_dly = 0;
        run(12, 1'b0, lat);

`ifdef CHANGE_TIMEOUT_EN
        hop_en = 1'b0;
        coin_q.push_back('{ctype: 1, rem: 5, cnt: 0});
        @(negedge CLK);
        bus.amount = 7'd5;
        bus.start  = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.coin_req) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("req_before_timeout", int'(got), 1);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge CLK);
            if (bus.err) begin
                lat = i;
                break;
            end
        end
        check("timeout_cycles", lat, int'(ACK_TO));
        check("err_coin_req", int'(bus.coin_req), 0);
        check("err_done", int'(bus.done), 0);
        repeat (3) @(negedge CLK);
        check("err_held", int'(bus.err), 1);
        hop_en = 1'b1;
        run(3, 1'b0, lat);
`endif

        for (int k = 0; k < 12; k++) begin
            amt     = int'($urandom_range(0, 127));
            hop_dly = int'($urandom_range(0, 5));
            run(amt, ($urandom_range(0, 1) == 1), lat);
        end

        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
